hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide engine that owns the HI/LO architectural registers.
//  Replaces the single-cycle HI_Reg/LO_Reg + ALU multiply path in the EX stage.
//  Adds a start/busy/done handshake, a hazard-stall output for mfhi/mflo, and a pipeline-flush abort.
//  Also adds multiply-accumulate/subtract and a defined divide-by-zero result.
// PARAMETERS
//  WIDTH   32  operand width and HI/LO width; must be even and >= 8
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  Clk        in   1      rising-edge clock
//  Rst        in   1      asynchronous reset, active-low
//  start      in   1      request an operation this cycle
//  op         in   4      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 NOP
//  rs_val     in   WIDTH  operand A / dividend / MTHI-MTLO source
//  rt_val     in   WIDTH  operand B / divisor
//  abort      in   1      flush: cancel the in-flight operation
//  hilo_rd    in   1      instruction in ID/EX reads HI or LO (mfhi/mflo)
//  start_ack  out  1      start accepted this cycle (combinational: start & ~busy & ~abort)
//  busy       out  1      iterative operation in flight
//  done       out  1      one-cycle pulse: HI/LO were updated by an iterative op
//  hilo_stall out  1      combinational: hilo_rd & busy
//  hi_out     out  WIDTH  HI register
//  lo_out     out  WIDTH  LO register
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE; hi_out=lo_out=0; busy=done=0; counter=0; operand regs=0.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE, accept (start_ack=1) with op 0-7: latch |A|,|B|, result signs and op; counter=WIDTH; go to RUN.
//  - IDLE, accept with op 8/9: write hi_out (8) or lo_out (9) with rs_val on that edge; stay in IDLE; no done pulse.
//  - IDLE, accept with op 10-15: no effect.
//  - RUN: one radix-2 step per cycle.
//    - Multiply: shift-add into a 2*WIDTH product register.
//    - Divide: restoring shift-subtract.
//    - Counter decrements each step; at count 1 -> FIX.
//  - FIX: apply sign correction.
//    - MADD*: {HI,LO} += product. MSUB*: {HI,LO} -= product (mod 2**(2*WIDTH)).
//    - Write HI/LO; done=1 for this one cycle; busy=0 from the next cycle; return to IDLE.
//  Timing: busy is high for WIDTH+1 cycles after the accept edge. HI/LO are valid on the cycle done=1.
//    Accept-to-done is WIDTH+1 edges.
//  start while busy: ignored, start_ack=0; the requester must hold start until acked.
//  A start in the cycle done=1 is accepted (busy is already 0 in that cycle).
//  Results:
//    - Multiply: HI=upper WIDTH bits, LO=lower WIDTH bits. Signed ops are two's-complement.
//    - Divide: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
//  Divide by zero: HI=rs_val, LO=all ones; full latency still applies; no exception.
//  Signed overflow (MIN / -1): LO=MIN, HI=0.
//  abort:
//    - In RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done pulse.
//    - In IDLE: blocks acceptance (start_ack=0).
//    - abort has priority over start.
//  Reset mid-operation: immediate return to reset values; the partial result is discarded.
//  hilo_stall is the only hazard interlock. mfhi/mflo read hi_out/lo_out directly once the stall drops.
// CONFIGURATION
//  HILO_FAST_MUL_EN defined:
//    - Ops 0,1,4-7 use a single-cycle combinational WIDTHxWIDTH multiplier.
//    - State goes IDLE->FIX; busy high 1 cycle; done one edge after accept (HI/LO written at the FIX edge).
//    - Divide timing unchanged.
//  HILO_FAST_MUL_EN undefined: all multiplies are iterative as above. This is the default, with no DSP inference.
// TESTING (WIDTH=32, macro undefined unless noted)
//  - Rst low mid-run -> hi_out=lo_out=0, busy=0 immediately (asynchronous, no clock edge needed).
//  - MULT rs=0xFFFFFFFD(-3), rt=7 -> done 33 edges after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high 33 cycles.
//  - DIV rs=0xFFFFFFF9(-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU 100/7 -> LO=14, HI=2.
//    DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
//  - MTHI 0x10, MTLO 0x20, then MADDU rs=3, rt=4 -> HI=0x10, LO=0x2C.
//    Then MSUB rs=1, rt=0x2D -> HI=0x0F, LO=0xFFFFFFFF.
//  - MULT accepted, abort at cycle 10 -> busy=0 next cycle; HI/LO unchanged; done never pulses.
//    A start during busy gets start_ack=0; hilo_rd during busy gives hilo_stall=1.
//  - HILO_FAST_MUL_EN defined: MULTU 0xFFFFFFFF*2 -> done one edge after accept; HI=1, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide engine owning HI/LO, with start/busy/done handshake and flush abort.
// Optional HILO_FAST_MUL_EN: single-cycle combinational multiplier for the multiply ops.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             hilo_rd,
  output logic             start_ack,
  output logic             busy,
  output logic             done,
  output logic             hilo_stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic                 sa, sb, div_in, div_q;
  logic [WIDTH-1:0]     abs_a, abs_b, quo, rem;
  logic [WIDTH:0]       msum, rem_s, diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_s, acc, mres, dres;
  assign sa     = ~op[0] & rs_val[WIDTH-1];
  assign sb     = ~op[0] & rt_val[WIDTH-1];
  assign abs_a  = sa ? -rs_val : rs_val;
  assign abs_b  = sb ? -rt_val : rt_val;
  assign div_in = op[2:1] == 2'b01;
  assign div_q  = op_q[2:1] == 2'b01;
  // prod_q holds the partial product, or {remainder, dividend/quotient} when dividing
  assign msum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {msum, prod_q[WIDTH-1:1]};
  assign rem_s    = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign diff     = rem_s - {1'b0, m_q};
  assign div_next = diff[WIDTH] ? {rem_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign prod_s = neg_q ? -prod_q : prod_q;
  assign acc    = {hi_q, lo_q};
  assign mres   = !op_q[2] ? prod_s : op_q[1] ? acc - prod_s : acc + prod_s;
  assign quo    = dz_q ? '1 : neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem    = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  assign dres   = {rem, quo};
  assign busy       = state_q != IDLE;
  assign start_ack  = start & ~busy & ~abort;
  assign hilo_stall = hilo_rd & busy;
  assign done       = done_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    m_d     = m_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start_ack) begin
        if (!op[3]) begin
          state_d = RUN;
          cnt_d   = CNT_W'(WIDTH);
          op_d    = op[2:0];
          m_d     = div_in ? abs_b : abs_a;
          prod_d  = {{WIDTH{1'b0}}, div_in ? abs_a : abs_b};
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = div_in && rt_val == '0;
`ifdef HILO_FAST_MUL_EN
          if (!div_in) begin
            prod_d  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
            state_d = FIX;
          end
`endif
        end else if (op == 4'd8) hi_d = rs_val;
        else if (op == 4'd9) lo_d = rs_val;
      end
      RUN: begin
        state_d = abort ? IDLE : cnt_q == CNT_W'(1) ? FIX : RUN;
        cnt_d   = cnt_q - CNT_W'(1);
        prod_d  = div_q ? div_next : mul_next;
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          {hi_d, lo_d} = div_q ? dres : mres;
          done_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      m_q     <= m_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed plus random checks of hilo_muldiv_unit against a 64-bit arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;
  logic        Clk = 1'b0, Rst = 1'b0, start = 1'b0, abort = 1'b0, hilo_rd = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        start_ack, busy, done, hilo_stall;
  logic [31:0] hi_out, lo_out;
  int          tests = 0, fails = 0;
  logic [31:0] mhi = '0, mlo = '0;
  logic [3:0]  ro;
  logic [31:0] ra, rb;
  int          nd;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Rst(Rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .hilo_rd(hilo_rd), .start_ack(start_ack), .busy(busy), .done(done),
    .hilo_stall(hilo_stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      4'd0: return 64'(sa * sb);
      4'd1: return ua * ub;
      4'd2, 4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = (o == 4'd2) ? 64'(sa / sb) : ua / ub;
        r = (o == 4'd2) ? 64'(sa % sb) : ua % ub;
        return {r[31:0], q[31:0]};
      end
      4'd4: return acc + 64'(sa * sb);
      4'd5: return acc + ua * ub;
      4'd6: return acc - 64'(sa * sb);
      4'd7: return acc - ua * ub;
      4'd8: return {a, acc[31:0]};
      4'd9: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  // Issue one op from a point 1 time unit after a rising edge; returns in the done cycle for iterative ops.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n, nb, lat;
    e = model(o, a, b, {mhi, mlo});
    lat = 33;
`ifdef HILO_FAST_MUL_EN
    if (o[2:1] != 2'b01) lat = 1;
`endif
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    chk("start_ack", start_ack, 1);
    @(posedge Clk); #1;
    start = 1'b0;
    if (o < 4'd8) begin
      n = 0; nb = 0;
      while (!done && n < 100) begin
        if (busy) nb++;
        @(posedge Clk); #1;
        n++;
      end
      chk("latency", n, lat);
      chk("busy_cycles", nb, lat);
      chk("busy_at_done", busy, 0);
    end else chk("no_done_nonarith", done, 0);
    {mhi, mlo} = e;
    chk("hi", hi_out, mhi);
    chk("lo", lo_out, mlo);
  endtask

  initial begin
    #12;
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    do_op(4'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi_const", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_out, 32'hFFFF_FFEB);
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", lo_out, 32'hFFFF_FFFD);
    chk("div_hi_const", hi_out, 32'hFFFF_FFFF);
    do_op(4'd3, 32'd100, 32'd7);
    chk("divu_lo_const", lo_out, 32'd14);
    chk("divu_hi_const", hi_out, 32'd2);
    do_op(4'd3, 32'd5, 32'd0);
    chk("dz_lo_const", lo_out, 32'hFFFF_FFFF);
    chk("dz_hi_const", hi_out, 32'd5);
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo_const", lo_out, 32'h8000_0000);
    chk("ovf_hi_const", hi_out, 32'd0);
    do_op(4'd8, 32'h10, 32'd0);
    do_op(4'd9, 32'h20, 32'd0);
    do_op(4'd5, 32'd3, 32'd4);
    chk("maddu_hi_const", hi_out, 32'h10);
    chk("maddu_lo_const", lo_out, 32'h2C);
    do_op(4'd6, 32'd1, 32'h2D);
    chk("msub_hi_const", hi_out, 32'h0F);
    chk("msub_lo_const", lo_out, 32'hFFFF_FFFF);
    do_op(4'd12, 32'h1234, 32'h5678);

    // abort mid-run, with a rejected start and a stalled mfhi while busy
    start = 1'b1; op = 4'd0; rs_val = 32'd5; rt_val = 32'd9;
    #1 chk("abort_ack", start_ack, 1);
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge Clk); #1; end
    start = 1'b1; op = 4'd1; hilo_rd = 1'b1;
    #1;
    chk("ack_while_busy", start_ack, 0);
    chk("stall_while_busy", hilo_stall, 1);
    chk("busy_before_abort", busy, 1);
    start = 1'b0; hilo_rd = 1'b0; abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    chk("busy_after_abort", busy, 0);
    hilo_rd = 1'b1;
    #1 chk("stall_idle", hilo_stall, 0);
    hilo_rd = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin @(posedge Clk); #1; if (done) nd++; end
    chk("no_done_after_abort", nd, 0);
    chk("abort_hi", hi_out, mhi);
    chk("abort_lo", lo_out, mlo);

    // abort in IDLE blocks acceptance
    start = 1'b1; abort = 1'b1; op = 4'd8; rs_val = 32'hBAD;
    #1 chk("ack_with_abort", start_ack, 0);
    @(posedge Clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_hi", hi_out, mhi);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb);
    end

    // asynchronous reset mid-operation
    do_op(4'd8, 32'hDEAD, 32'd0);
    start = 1'b1; op = 4'd0; rs_val = $urandom; rt_val = $urandom;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge Clk); #1; end
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_hi", hi_out, 0);
    chk("async_rst_lo", lo_out, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    mhi = '0; mlo = '0;
    @(posedge Clk); #1;
    do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", hi_out, 32'd1);
    chk("multu_lo_const", lo_out, 32'hFFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
